// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM encoding, round constants and sizes for AES-128 key expansion
package aes_pkg;
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;
   localparam int NUM_RK = 11;
   localparam int AES_WORD_W = 32;
   localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   assign y = SBOX[a];
endmodule

// File: rtl/aes_key_expansion.sv
// aes_key_expansion: captures a key on a key_valid rising edge and expands it into 11 round keys, one per cycle
module aes_key_expansion
   import aes_pkg::*;
#(
   parameter int KEY_LEN_P    = 128,
   parameter int NUM_ROUNDS_P = 10,
   parameter int RK_ADDR_W_P  = 4
) (
   input  logic                   clock,
   input  logic                   preset,
   input  logic [KEY_LEN_P-1:0]   key_in,
   input  logic                   key_valid,
   input  logic [RK_ADDR_W_P-1:0] rk_addr,
   output logic [KEY_LEN_P-1:0]   rk_data,
   output logic                   busy,
   output logic                   keys_ready,
   output logic                   key_dropped
);
   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS_P);
   localparam logic [RK_ADDR_W_P-1:0] MAX_ADDR = RK_ADDR_W_P'(NUM_RK - 1);
   state_e state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [KEY_LEN_P-1:0] w_q, w_d, rk_data_q, rk_data_d, nxt, wdata;
   logic key_valid_q, key_dropped_q, key_dropped_d, key_edge, we;
   logic [3:0] waddr;
   logic [KEY_LEN_P-1:0] rk_q [0:NUM_RK-1];
   logic [AES_WORD_W-1:0] rot, sub, t, w0n, w1n, w2n, w3n;
   assign key_edge = key_valid & ~key_valid_q;
   // RotWord: bytes a0a1a2a3 -> a1a2a3a0
   assign rot = {w_q[23:0], w_q[31:24]};
   for (genvar i = 0; i < 4; i++) begin : g_sb
      aes_sbox u_sb (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
   end
   assign t   = sub ^ {RCON[round_q], 24'h0};
   assign w0n = w_q[127:96] ^ t;
   assign w1n = w_q[95:64] ^ w0n;
   assign w2n = w_q[63:32] ^ w1n;
   assign w3n = w_q[31:0] ^ w2n;
   assign nxt = {w0n, w1n, w2n, w3n};
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      w_d = w_q;
      we = 1'b0;
      waddr = round_q;
      wdata = nxt;
      key_dropped_d = key_edge && state_q == EXPAND;
      rk_data_d = rk_addr <= MAX_ADDR ? rk_q[rk_addr] : '0;
      if (state_q != EXPAND && key_edge) begin
         state_d = EXPAND;
         round_d = 4'd1;
         w_d = key_in;
         we = 1'b1;
         waddr = 4'd0;
         wdata = key_in;
      end else if (state_q == EXPAND) begin
         w_d = nxt;
         we = 1'b1;
         state_d = round_q == LAST_RND ? DONE : EXPAND;
         round_d = round_q == LAST_RND ? round_q : round_q + 4'd1;
      end
   end
   always_ff @(posedge clock) begin
      if (preset) begin
         state_q <= IDLE;
         round_q <= '0;
         key_valid_q <= 1'b0;
         key_dropped_q <= 1'b0;
         rk_data_q <= '0;
         w_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         key_valid_q <= key_valid;
         key_dropped_q <= key_dropped_d;
         rk_data_q <= rk_data_d;
         w_q <= w_d;
      end
   end
   // Schedule storage is never cleared; keys_ready qualifies its contents
   always_ff @(posedge clock) begin
      if (we && !preset) rk_q[waddr] <= wdata;
   end
   assign rk_data = rk_data_q;
   assign busy = state_q == EXPAND;
   assign keys_ready = state_q == DONE;
   assign key_dropped = key_dropped_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// tb_aes_key_expansion: table vectors, corner-case sequences and random keys against a math-derived key schedule
module tb_aes_key_expansion;
   logic clock = 1'b0, preset = 1'b1, key_valid = 1'b0;
   logic [127:0] key_in = '0, rk_data;
   logic [3:0] rk_addr = '0;
   logic busy, keys_ready, key_dropped;
   int n_vec = 0, n_bad = 0, busy_cnt, drop_cnt;
   logic [7:0] sb [256];
   logic [7:0] rc [1:10];
   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   aes_key_expansion dut (.clock(clock), .preset(preset), .key_in(key_in), .key_valid(key_valid),
      .rk_addr(rk_addr), .rk_data(rk_data), .busy(busy), .keys_ready(keys_ready), .key_dropped(key_dropped));
   always #5 clock = ~clock;
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      end
      return p;
   endfunction
   function automatic logic [7:0] rotl8(logic [7:0] b, int n);
      return (b << n) | (b >> (8 - n));
   endfunction
   function automatic logic [127:0] ref_rk(logic [127:0] key, int r);
      logic [31:0] w [44];
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc[i/4], 24'h0};
         end
         w[i] = w[i-4] ^ tmp;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask
   task automatic rd(logic [3:0] a, logic [127:0] exp, string nm);
      rk_addr = a;
      step();
      check(nm, rk_data, exp);
   endtask
   task automatic load(logic [127:0] k, int exp_lat);
      int lat;
      key_in = k;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      lat = 1;
      busy_cnt = int'(busy);
      drop_cnt = int'(key_dropped);
      while (!keys_ready && lat < 40) begin
         step();
         lat++;
         busy_cnt += int'(busy);
         drop_cnt += int'(key_dropped);
      end
      if (exp_lat > 0) check("ready_latency", 128'(lat), 128'(exp_lat));
   endtask
   typedef struct {logic [127:0] key; logic [3:0] addr; logic [127:0] exp;} vec_t;
   vec_t tbl [9];
   initial begin
      logic [7:0] inv, r;
      logic [127:0] k, cur;
      int rises;
      logic pb;
      for (int a = 0; a < 256; a++) begin
         inv = 0;
         for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      r = 8'h01;
      for (int i = 1; i <= 10; i++) begin
         rc[i] = r;
         r = gmul(r, 8'h02);
      end
      tbl[0] = '{K1, 4'd0, K1};
      tbl[1] = '{K1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605};
      tbl[2] = '{K1, 4'd2, 128'hf2c295f27a96b9435935807a7359f67f};
      tbl[3] = '{K1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      tbl[4] = '{K1, 4'd11, 128'h0};
      tbl[5] = '{K1, 4'd15, 128'h0};
      tbl[6] = '{128'h0, 4'd1, 128'h62636363626363636263636362636363};
      tbl[7] = '{128'h0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      tbl[8] = '{128'h0, 4'd0, 128'h0};
      repeat (3) step();
      check("rst_busy", 128'(busy), 0);
      check("rst_keys_ready", 128'(keys_ready), 0);
      check("rst_key_dropped", 128'(key_dropped), 0);
      check("rst_rk_data", rk_data, 0);
      preset = 1'b0;
      step();
      load(K1, 11);
      check("a1_busy_cycles", 128'(busy_cnt), 10);
      cur = K1;
      foreach (tbl[i]) begin
         if (tbl[i].key !== cur) begin
            load(tbl[i].key, 11);
            cur = tbl[i].key;
         end
         rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_rk%0d", i, tbl[i].addr));
      end
      // held-high key_valid from DONE: one accept, no drops
      key_in = K1;
      key_valid = 1'b1;
      busy_cnt = 0;
      drop_cnt = 0;
      rises = 0;
      pb = busy;
      repeat (300) begin
         step();
         busy_cnt += int'(busy);
         drop_cnt += int'(key_dropped);
         if (busy && !pb) rises++;
         pb = busy;
      end
      key_valid = 1'b0;
      check("held_expansions", 128'(rises), 1);
      check("held_busy_cycles", 128'(busy_cnt), 10);
      check("held_drops", 128'(drop_cnt), 0);
      check("held_ready", 128'(keys_ready), 1);
      step();
      // second edge mid-expansion is dropped
      key_in = K1;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      drop_cnt = 0;
      repeat (3) step();
      key_in = '0;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      for (int i = 0; i < 20 && !keys_ready; i++) begin
         drop_cnt += int'(key_dropped);
         step();
      end
      drop_cnt += int'(key_dropped);
      check("mid_drop_count", 128'(drop_cnt), 1);
      check("mid_ready", 128'(keys_ready), 1);
      rd(4'd10, ref_rk(K1, 10), "mid_rk10");
      // new edge in DONE drops keys_ready next cycle
      key_in = '0;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      check("done_edge_ready_drop", 128'(keys_ready), 0);
      for (int i = 0; i < 20 && !keys_ready; i++) step();
      check("done_edge_ready", 128'(keys_ready), 1);
      rd(4'd1, ref_rk(0, 1), "zero_rk1");
      rd(4'd10, ref_rk(0, 10), "zero_rk10");
      // reset mid-expansion
      key_in = K1;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      repeat (2) step();
      preset = 1'b1;
      step();
      preset = 1'b0;
      check("rst_mid_busy", 128'(busy), 0);
      check("rst_mid_ready", 128'(keys_ready), 0);
      check("rst_mid_rk_data", rk_data, 0);
      step();
      check("rst_mid_stays_idle", 128'(busy), 0);
      load(K1, 11);
      rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "post_rst_rk1");
      rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_rst_rk10");
      // random keys against the reference schedule
      for (int n = 0; n < 12; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         load(k, 11);
         check("rnd_busy_cycles", 128'(busy_cnt), 10);
         for (int a = 0; a < 11; a++) rd(4'(a), ref_rk(k, a), $sformatf("rnd%0d_rk%0d", n, a));
         rd(4'($urandom_range(11, 15)), 0, "rnd_oob");
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
